sprite_mem_writer: RTL and testbench

- Loads one sprite of RGB pixel data into the sprite memory, which the sprite read path later fetches pixel by pixel.
- Takes a start command with a sprite_id, accepts a valid/ready pixel stream in raster order, and issues registered single-port write cycles (wren/address/data) toward the memory.
- Provides a running checksum so benches and host software can compare it against readback from the read side.

---
 rtl/sprite_mem_writer.sv | 111 +++++++++++
 tb/tb_sprite_mem_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mem_writer.sv
// Sprite loader: accepts a raster-ordered RGB pixel stream for one sprite and
// issues registered single-port memory writes at {id, y, x}, keeping a running checksum.
module sprite_mem_writer #(
  parameter  int PIXEL_W  = 24,
  parameter  int ID_W     = 5,
  parameter  int DIM_LOG2 = 4,
  localparam int ADDR_W   = ID_W + 2*DIM_LOG2
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic [ID_W-1:0]    start_id,
  input  logic               abort,
  input  logic               pix_valid,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic               pix_ready,
  output logic               mem_wren,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0] mem_data,
  output logic               busy,
  output logic               done,
  output logic               err_start,
  output logic [PIXEL_W-1:0] checksum
);

  localparam int CNT_W = 2*DIM_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PIXEL_W-1:0]   sum_q, sum_d;
  logic                 wren_q, wren_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [PIXEL_W-1:0]   data_q, data_d;
  logic                 err_q, err_d;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start beats a simultaneous abort; abort means nothing while idle
        if (start) begin
          id_d    = start_id;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        err_d = start;
        // abort drops any pixel presented in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (pix_valid) begin
          wren_d = 1'b1;
          addr_d = {id_q, cnt_q};
          data_d = pix_data;
          sum_d  = sum_q + pix_data;
          cnt_d  = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = start;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pix_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_wren  = wren_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign err_start = err_q;
  assign checksum  = sum_q;

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Directed bench for sprite_mem_writer: table of full-sprite loads plus
// hand-written abort, start-while-busy and asynchronous-reset sequences.
module tb_sprite_mem_writer;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  start_id;
  logic        abort;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        mem_wren;
  logic [12:0] mem_addr;
  logic [23:0] mem_data;
  logic        busy;
  logic        done;
  logic        err_start;
  logic [23:0] checksum;

  sprite_mem_writer dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .start_id  (start_id),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .err_start (err_start),
    .checksum  (checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  id;
    int          mode;
    bit          toggle;
    logic [12:0] last_addr;
    logic [23:0] exp_sum;
  } vec_t;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int ndone;
  int err_pulses;
  logic        done_wren;
  logic [12:0] done_addr;
  logic [12:0] wa[$];
  logic [23:0] wd[$];
  int          wc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pixval(input int mode, input int i);
    return (mode == 1) ? 24'hFFFFFF : 24'(i);
  endfunction

  // advance one clock and log what the DUT shows just after the edge
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (mem_wren) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
    if (done) begin
      ndone++;
      done_wren = mem_wren;
      done_addr = mem_addr;
    end
    if (err_start) err_pulses++;
  endtask

  task automatic do_load(input logic [4:0] id, input int mode, input bit toggle,
                         input int abort_at, input int start_at, output bit aborted);
    int  i;
    int  budget;
    bit  xfer;
    wa.delete(); wd.delete(); wc.delete();
    ndone = 0; err_pulses = 0; done_wren = 1'b0; done_addr = '0;
    start = 1'b1; start_id = id;
    step();
    start = 1'b0; start_id = '0;
    i = 0; budget = 0; aborted = 1'b0;
    while (i < 256 && !aborted && budget < 2000) begin
      pix_valid = toggle ? (budget % 2 == 0) : 1'b1;
      pix_data  = pixval(mode, i);
      abort     = pix_valid && (i == abort_at);
      start     = pix_valid && (i == start_at);
      start_id  = start ? 5'd5 : 5'd0;
      xfer      = pix_valid && pix_ready && !abort;
      if (abort) aborted = 1'b1;
      step();
      start = 1'b0; abort = 1'b0; start_id = '0;
      if (xfer) i++;
      budget++;
    end
    pix_valid = 1'b0;
    pix_data  = '0;
    chk("load_budget", 32'(budget >= 2000), 32'd0);
  endtask

  task automatic full_checks(input logic [4:0] id, input int mode, input bit toggle,
                             input logic [12:0] last, input logic [23:0] sum, input int exp_err);
    int bad_a = 0, bad_d = 0, bad_g = 0;
    chk("nwrites", wa.size(), 256);
    for (int k = 0; k < wa.size(); k++) begin
      if (wa[k] !== {id, 8'(k)}) bad_a++;
      if (wd[k] !== pixval(mode, k)) bad_d++;
      if (k > 0 && (wc[k] - wc[k-1]) != (toggle ? 2 : 1)) bad_g++;
    end
    chk("addr_seq", bad_a, 0);
    chk("data_seq", bad_d, 0);
    chk("wren_gaps", bad_g, 0);
    chk("last_addr", (wa.size() > 0) ? wa[wa.size()-1] : 13'h0, last);
    chk("ndone", ndone, 1);
    chk("done_with_wren", done_wren, 1);
    chk("done_addr", done_addr, last);
    chk("busy_at_done", busy, 1);
    chk("checksum", checksum, sum);
    chk("err_pulses", err_pulses, exp_err);
    step();
    chk("busy_after_done", busy, 0);
    chk("ready_after_done", pix_ready, 0);
  endtask

  initial begin
    vec_t vecs[3];
    bit   ab;
    vecs[0] = '{id: 5'd3,  mode: 0, toggle: 1'b0, last_addr: 13'h03FF, exp_sum: 24'h007F80};
    vecs[1] = '{id: 5'd3,  mode: 0, toggle: 1'b1, last_addr: 13'h03FF, exp_sum: 24'h007F80};
    vecs[2] = '{id: 5'd31, mode: 1, toggle: 1'b0, last_addr: 13'h1FFF, exp_sum: 24'hFFFF00};

    rst = 1'b0; start = 1'b0; start_id = '0; abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
    #3;
    chk("rst_outputs", {pix_ready, mem_wren, busy, done, err_start, mem_addr, mem_data, checksum}, 0);
    chk("rst_mem_data", mem_data, 0);
    @(negedge clock);
    rst = 1'b1;

    for (int v = 0; v < 3; v++) begin
      do_load(vecs[v].id, vecs[v].mode, vecs[v].toggle, -1, -1, ab);
      full_checks(vecs[v].id, vecs[v].mode, vecs[v].toggle, vecs[v].last_addr, vecs[v].exp_sum, 0);
    end

    // start while busy at pixel 10 of sprite 1
    do_load(5'd1, 0, 1'b0, -1, 10, ab);
    full_checks(5'd1, 0, 1'b0, 13'h01FF, 24'h007F80, 1);

    // abort coincident with pixel 100 of sprite 2
    do_load(5'd2, 0, 1'b0, 100, -1, ab);
    chk("abort_seen", ab, 1);
    chk("abort_nwrites", wa.size(), 100);
    chk("abort_last_addr", (wa.size() > 0) ? wa[wa.size()-1] : 13'h0, 13'h0263);
    chk("abort_ready", pix_ready, 0);
    chk("abort_wren", mem_wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ndone", ndone, 0);
    chk("abort_checksum", checksum, 24'h001356);
    chk("abort_addr_hold", mem_addr, 13'h0263);
    step();
    chk("abort_no_done_late", ndone, 0);

    // asynchronous reset in the middle of a load of sprite 4
    start = 1'b1; start_id = 5'd4;
    step();
    start = 1'b0; start_id = '0;
    for (int k = 0; k < 20; k++) begin
      pix_valid = 1'b1; pix_data = 24'h0A0B00 + 24'(k);
      step();
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_addr", mem_addr, 13'h0413);
    #2;
    pix_valid = 1'b0; rst = 1'b0;
    #1;
    chk("async_rst_outputs", {pix_ready, mem_wren, busy, done, err_start}, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_data", mem_data, 0);
    chk("async_rst_checksum", checksum, 0);
    #10;
    rst = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);
    do_load(5'd6, 0, 1'b0, -1, -1, ab);
    full_checks(5'd6, 0, 1'b0, 13'h06FF, 24'h007F80, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
